// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment scan controller:
// hex->segment table (active-high, bit order g..a), idle pin levels and FSM states.
package seg7_pkg;

   localparam int DIGITS = 4;

   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic [3:0] AN_OFF  = 4'hF;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_t;

   // Index = nibble value, entry = {g,f,e,d,c,b,a}, 1 = segment lit
   localparam logic [6:0] HEX_SEG_TBL [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
      7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
      7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
      7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
   };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Host-side write/commit port of the scan controller.
// master = user logic writing digits, slave = seg7_scan_ctrl.
interface seg7_scan_ctrl_if;

   logic       wr_en;
   logic [1:0] wr_idx;
   logic [3:0] wr_data;
   logic       wr_dp;
   logic       wr_blank;
   logic       commit_req;
   logic       commit_ack;

   modport master (
      output wr_en, wr_idx, wr_data, wr_dp, wr_blank, commit_req,
      input  commit_ack
   );

   modport slave (
      input  wr_en, wr_idx, wr_data, wr_dp, wr_blank, commit_req,
      output commit_ack
   );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble -> active-high g..a segment pattern.
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   assign o_seg = HEX_SEG_TBL[i_hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-seg display.
// Host writes land in a shadow bank; a commit copies shadow -> active only at a
// frame boundary so a frame is never drawn from a half-updated set.
// Each digit slot starts with BLANK_CYC cycles of all anodes off (anti-ghosting).
// Optional build macro LZ_SUPPRESS_EN: blank leading zero digits (digit 0 always shown).
//
//  state    | meaning
//  ST_BLANK | slot preamble, all anodes off, cathodes off
//  ST_DRIVE | current digit's anode on (unless blanked), cathodes show its value
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_CYC   = 1000
) (
   input  logic               clk,
   input  logic               rst_n,
   seg7_scan_ctrl_if.slave    host,
   output logic               o_frame_tick,
   output logic [7:0]         o_seg,
   output logic [3:0]         o_an
);

   localparam int                CNT_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0]  BLANK_LIM = CNT_W'(BLANK_CYC);

   logic [CNT_W-1:0]             r_cnt;
   logic [1:0]                   r_digit;
   scan_state_t                  r_state;
   scan_state_t                  w_state_nxt;

   logic [DIGITS-1:0][3:0]       r_sh_val;
   logic [DIGITS-1:0]            r_sh_dp;
   logic [DIGITS-1:0]            r_sh_blank;
   logic [DIGITS-1:0][3:0]       r_act_val;
   logic [DIGITS-1:0]            r_act_dp;
   logic [DIGITS-1:0]            r_act_blank;

   logic                         r_pending;
   logic                         r_ack;
   logic                         r_tick;
   logic [7:0]                   r_seg;
   logic [3:0]                   r_an;

   logic                         w_wrap;
   logic [CNT_W-1:0]             w_cnt_nxt;
   logic                         w_boundary;
   logic                         w_commit;
   logic [6:0]                   w_hex_seg;
   logic                         w_sup;
   logic [7:0]                   w_seg_nxt;
   logic [3:0]                   w_an_nxt;

   assign w_wrap     = (r_cnt == CNT_LAST);
   assign w_cnt_nxt  = w_wrap ? '0 : r_cnt + 1'b1;
   assign w_boundary = w_wrap && (r_digit == 2'd3);
   // A request arriving in the boundary cycle itself still catches this boundary
   assign w_commit   = w_boundary && (r_pending || host.commit_req);

   // Slot prescaler and digit pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_digit <= 2'd0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (w_wrap) r_digit <= r_digit + 2'd1;
      end
   end

   // FSM state register; state always describes the current r_cnt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_BLANK;
      else        r_state <= w_state_nxt;
   end

   // FSM next state, looked ahead from the next counter value
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_BLANK: if (w_cnt_nxt >= BLANK_LIM)       w_state_nxt = ST_DRIVE;
         ST_DRIVE: if (w_wrap && (BLANK_CYC != 0))   w_state_nxt = ST_BLANK;
         default:                                    w_state_nxt = ST_BLANK;
      endcase
   end

   // Shadow bank: every write accepted, never visible on pins until committed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_val   <= '0;
         r_sh_dp    <= '0;
         r_sh_blank <= '1;
      end else if (host.wr_en) begin
         r_sh_val[host.wr_idx]   <= host.wr_data;
         r_sh_dp[host.wr_idx]    <= host.wr_dp;
         r_sh_blank[host.wr_idx] <= host.wr_blank;
      end
   end

   // Active bank: copied from pre-write shadow at a boundary with a commit outstanding
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_act_val   <= '0;
         r_act_dp    <= '0;
         r_act_blank <= '1;
      end else if (w_commit) begin
         r_act_val   <= r_sh_val;
         r_act_dp    <= r_sh_dp;
         r_act_blank <= r_sh_blank;
      end
   end

   // Commit bookkeeping: requests merge while pending; each boundary clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= 1'b0;
         r_ack     <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         if (w_boundary)           r_pending <= 1'b0;
         else if (host.commit_req) r_pending <= 1'b1;
         r_ack  <= w_commit;
         r_tick <= w_boundary;
      end
   end

   hex_to_seg7 u_hex (
      .i_hex (r_act_val[r_digit]),
      .o_seg (w_hex_seg)
   );

`ifdef LZ_SUPPRESS_EN
   logic [DIGITS-1:0] w_lz_vec;

   // Walk from the top digit down; suppression stops at the first significant digit
   always_comb begin
      logic run;
      logic zero;
      w_lz_vec = '0;
      run      = 1'b1;
      zero     = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero        = (r_act_val[i] == 4'd0) && !r_act_dp[i];
         w_lz_vec[i] = run && zero && (i != 0);
         run         = run && (zero || r_act_blank[i]);
      end
   end

   assign w_sup = w_lz_vec[r_digit];
`else
   assign w_sup = 1'b0;
`endif

   // Pin values for the current state/counter, registered below
   always_comb begin
      w_an_nxt  = AN_OFF;
      w_seg_nxt = SEG_OFF;
      if (r_state == ST_DRIVE) begin
         w_seg_nxt = {~r_act_dp[r_digit], ~w_hex_seg};
         if (!r_act_blank[r_digit] && !w_sup) w_an_nxt = ~(4'b0001 << r_digit);
      end
   end

   // Registered pins: one cycle behind the scan state, glitch-free at the board
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg <= SEG_OFF;
         r_an  <= AN_OFF;
      end else begin
         r_seg <= w_seg_nxt;
         r_an  <= w_an_nxt;
      end
   end

   assign o_seg           = r_seg;
   assign o_an            = r_an;
   assign o_frame_tick    = r_tick;
   assign host.commit_ack = r_ack;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with a short refresh period. The reference model
// derives slot position from the cycle count since reset and keeps shadow/active
// digit sets as plain arrays.
module tb_seg7_scan_ctrl;

   localparam int RD    = 8;
   localparam int BC    = 2;
   localparam int FRAME = RD * 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick;
   logic [7:0] seg;
   logic [3:0] an;

   seg7_scan_ctrl_if bus ();

   seg7_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .host         (bus.slave),
      .o_frame_tick (frame_tick),
      .o_seg        (seg),
      .o_an         (an)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   bit [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int       m_n;
   bit [3:0] m_sh_val  [4];
   bit       m_sh_dp   [4];
   bit       m_sh_blk  [4];
   bit [3:0] m_act_val [4];
   bit       m_act_dp  [4];
   bit       m_act_blk [4];
   bit       m_pending;
   int       acks_seen;
   int       an_d_seen;

   function automatic void model_reset();
      m_n       = 0;
      m_pending = 0;
      for (int i = 0; i < 4; i++) begin
         m_sh_val[i] = 0;  m_sh_dp[i] = 0;  m_sh_blk[i] = 1;
         m_act_val[i] = 0; m_act_dp[i] = 0; m_act_blk[i] = 1;
      end
   endfunction

   function automatic bit lz_suppressed(input int d);
`ifdef LZ_SUPPRESS_EN
      if (d == 0) return 0;
      if (m_act_val[d] != 0 || m_act_dp[d]) return 0;
      for (int k = d + 1; k < 4; k++)
         if (!((m_act_val[k] == 0 && !m_act_dp[k]) || m_act_blk[k])) return 0;
      return 1;
`else
      return (d < 0);
`endif
   endfunction

   // One clock: predict pins from the pre-edge view, check after the edge, then update the model
   task automatic step();
      int       cnt;
      int       dig;
      bit       bnd;
      bit       exp_ack;
      bit [3:0] exp_an;
      bit [7:0] exp_seg;
      cnt     = m_n % RD;
      dig     = (m_n / RD) % 4;
      bnd     = (cnt == RD - 1) && (dig == 3);
      exp_ack = bnd && (m_pending || bus.commit_req);
      exp_an  = 4'hF;
      exp_seg = 8'hFF;
      if (cnt >= BC) begin
         exp_seg = {~m_act_dp[dig], ~tbl[m_act_val[dig]]};
         if (!m_act_blk[dig] && !lz_suppressed(dig)) exp_an = ~(4'(1) << dig);
      end
      @(posedge clk);
      #1;
      chk_eq("an",         32'(an),             32'(exp_an));
      chk_eq("seg",        32'(seg),            32'(exp_seg));
      chk_eq("frame_tick", 32'(frame_tick),     32'(bnd));
      chk_eq("commit_ack", 32'(bus.commit_ack), 32'(exp_ack));
      if (bus.commit_ack) acks_seen++;
      if (an == 4'hD)     an_d_seen++;
      if (exp_ack) begin
         for (int i = 0; i < 4; i++) begin
            m_act_val[i] = m_sh_val[i];
            m_act_dp[i]  = m_sh_dp[i];
            m_act_blk[i] = m_sh_blk[i];
         end
      end
      if (bnd)                 m_pending = 0;
      else if (bus.commit_req) m_pending = 1;
      if (bus.wr_en) begin
         m_sh_val[bus.wr_idx] = bus.wr_data;
         m_sh_dp[bus.wr_idx]  = bus.wr_dp;
         m_sh_blk[bus.wr_idx] = bus.wr_blank;
      end
      m_n++;
      bus.wr_en      = 1'b0;
      bus.commit_req = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic set_wr(input int idx, input int data, input bit dp, input bit blk);
      bus.wr_en    = 1'b1;
      bus.wr_idx   = 2'(idx);
      bus.wr_data  = 4'(data);
      bus.wr_dp    = dp;
      bus.wr_blank = blk;
   endtask

   task automatic write(input int idx, input int data, input bit dp, input bit blk);
      set_wr(idx, data, dp, blk);
      step();
   endtask

   task automatic commit();
      bus.commit_req = 1'b1;
      step();
   endtask

   task automatic goto_phase(input int p);
      for (int i = 0; i < FRAME && (m_n % FRAME) != p; i++) step();
   endtask

   int a0;

   initial begin
      bus.wr_en = 0; bus.wr_idx = 0; bus.wr_data = 0; bus.wr_dp = 0;
      bus.wr_blank = 0; bus.commit_req = 0;
      acks_seen = 0; an_d_seen = 0;
      model_reset();

      #12;
      chk_eq("rst_an",   32'(an),             32'h0F);
      chk_eq("rst_seg",  32'(seg),            32'hFF);
      chk_eq("rst_tick", 32'(frame_tick),     32'h0);
      chk_eq("rst_ack",  32'(bus.commit_ack), 32'h0);
      rst_n = 1'b1;

      // dark display for two frames, frame ticks only
      idle(2 * FRAME);
      chk_eq("no_ack_idle", 32'(acks_seen), 32'h0);

      // digits 1,2,3,4 then a single commit pulse
      for (int i = 0; i < 4; i++) write(i, i + 1, 1'b0, 1'b0);
      a0 = acks_seen;
      commit();
      idle(2 * FRAME);
      chk_eq("first_commit_acks", 32'(acks_seen - a0), 32'h1);

      // write + commit in the boundary cycle: old idx2 for one frame, A. after next commit
      goto_phase(FRAME - 1);
      set_wr(2, 4'hA, 1'b1, 1'b0);
      bus.commit_req = 1'b1;
      step();
      idle(FRAME);
      commit();
      idle(2 * FRAME);

      // three requests in one frame merge into one copy
      goto_phase(3);
      a0 = acks_seen;
      commit(); idle(5); commit(); idle(5); commit();
      goto_phase(FRAME - 1);
      idle(FRAME);
      chk_eq("merged_acks", 32'(acks_seen - a0), 32'h1);

      // blanked digit 1 never lights its anode
      write(1, 7, 1'b0, 1'b1);
      commit();
      goto_phase(0);
      an_d_seen = 0;
      idle(2 * FRAME);
      chk_eq("an_D_count", 32'(an_d_seen), 32'h0);

      // reset mid-DRIVE of digit 2 with a commit pending
      write(0, 9, 1'b0, 1'b0);
      goto_phase(2 * RD + 3);
      commit();
      step();
      rst_n = 1'b0;
      #1;
      chk_eq("midrst_an",   32'(an),             32'h0F);
      chk_eq("midrst_seg",  32'(seg),            32'hFF);
      chk_eq("midrst_ack",  32'(bus.commit_ack), 32'h0);
      chk_eq("midrst_tick", 32'(frame_tick),     32'h0);
      model_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      a0 = acks_seen;
      idle(2 * FRAME);
      chk_eq("post_rst_acks", 32'(acks_seen - a0), 32'h0);
      for (int i = 0; i < 4; i++) write(i, 4'hC + i, 1'(i), 1'b0);
      commit();
      idle(FRAME + 4);

      // randomized traffic
      for (int i = 0; i < 900; i++) begin
         if ($urandom_range(3) == 0)
            set_wr(int'($urandom_range(3)), int'($urandom_range(15)),
                   1'($urandom_range(1)), ($urandom_range(7) == 0));
         if ($urandom_range(19) == 0) bus.commit_req = 1'b1;
         step();
      end

`ifdef LZ_SUPPRESS_EN
      write(3, 0, 1'b0, 1'b0); write(2, 0, 1'b0, 1'b0);
      write(1, 0, 1'b0, 1'b0); write(0, 7, 1'b0, 1'b0);
      commit();
      goto_phase(0);
      idle(FRAME);
      write(0, 0, 1'b0, 1'b0);
      commit();
      goto_phase(0);
      idle(FRAME);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
